// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Also holds the command/reply byte values used by the receive side.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_REL,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] REPLY_ACK    = 8'hFA;
  localparam logic [7:0] REPLY_RESEND = 8'hFE;

  // Falling-edge numbers within a frame; edges 1-8 carry D0..D7.
  localparam logic [3:0] EDGE_LAST_DATA = 4'd8;
  localparam logic [3:0] EDGE_PARITY    = 4'd9;
  localparam logic [3:0] EDGE_STOP      = 4'd10;
  localparam logic [3:0] EDGE_ACK       = 4'd11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// Multi-flop synchroniser for one PS/2 line plus a registered falling-edge pulse.
// Flops reset high so a released (idle) line never produces a spurious edge.
module ps2_host_tx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic raw_i,
  output logic sync_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   fall_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (one byte per request, open-collector low-enables).
// Optional per-frame watchdog enabled by defining PS2_TX_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | lines released, tx_ready high, waiting for tx_valid
// INHIBIT  | hold ps2_clk low for INHIBIT_CYCLES
// REQ      | start bit on data, clock released next cycle
// SEND     | shift D0..D7, parity, stop on device clock falls; sample ACK on edge 11
// WAIT_REL | wait for device to release clock and data
// DONE     | one-cycle tx_done
// ERR      | one-cycle tx_err, lines released
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);

  state_t             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic               parity_q, parity_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic [3:0]         edge_n;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;

  ps2_host_tx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .raw_i    (ps2_clk_in),
    .sync_o   (clk_sync),
    .fall_o   (clk_fall)
  );

  // Data edges belong to the receive path; only the level is needed here.
  ps2_host_tx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .raw_i    (ps2_data_in),
    .sync_o   (data_sync),
    .fall_o   (data_fall_unused)
  );

  assign edge_n = bit_cnt_q + 4'd1;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d   = tx_data;
          parity_d  = odd_parity(tx_data);
          bit_cnt_d = '0;
          inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == '0) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end
      REQ: begin
        clk_oe_d = 1'b0;
        state_d  = SEND;
      end
      SEND: begin
        if (clk_fall) begin
          if (bit_cnt_q != EDGE_ACK) bit_cnt_d = edge_n;
          if (edge_n <= EDGE_LAST_DATA) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (edge_n == EDGE_PARITY) begin
            data_oe_d = ~parity_q;
          end else if (edge_n == EDGE_STOP) begin
            data_oe_d = 1'b0;
          end else begin
            data_oe_d = 1'b0;
            state_d   = data_sync ? ERR : WAIT_REL;
          end
        end
      end
      WAIT_REL: begin
        if (clk_sync && data_sync) state_d = DONE;
      end
      DONE: state_d = IDLE;
      ERR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_cnt_d = wd_cnt_q;
    if (state_q == IDLE) begin
      if (tx_valid) wd_cnt_d = WD_W'(TIMEOUT_CYCLES - 1);
    end else if (wd_cnt_q != '0) begin
      wd_cnt_d = wd_cnt_q - 1'b1;
    end else if (state_q != DONE && state_q != ERR) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = ERR;
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) wd_cnt_q <= '0;
    else         wd_cnt_q <= wd_cnt_d;
  end
`endif

  assign tx_ready    = (state_q == IDLE);
  assign tx_done     = (state_q == DONE);
  assign tx_err      = (state_q == ERR);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device and a frame scoreboard.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int HALF       = 25;
  localparam int TB_TIMEOUT = 20000;
  localparam int FRAME_MAX  = 20000;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  bit   model_ack    = 1'b1;
  bit   model_silent = 1'b0;
  bit   model_abort  = 1'b0;
  bit   model_busy   = 1'b0;
  int   dev_edge     = 0;
  logic [10:0] last_frame = '0;
  logic [10:0] exp_q[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0, clk_run = 0, last_run = 0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {stop, odd parity, D7..D0, start}
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  always @(negedge CLOCK_50) begin
    if (tx_done) done_cnt++;
    if (tx_err)  err_cnt++;
    if (ps2_clk_oe) clk_run++;
    else begin
      if (clk_run != 0) last_run = clk_run;
      clk_run = 0;
    end
  end

  always @(posedge CLOCK_50) if (resetn && tx_valid && tx_ready) acc_cnt++;

  // Device: clocks 11 edges once the host releases clock with data low.
  initial begin
    logic [10:0] frame;
    forever begin
      @(negedge CLOCK_50);
      if (resetn && ps2_data_oe && !ps2_clk_oe && !model_silent) begin
        model_busy = 1'b1;
        frame = '0;
        frame[0] = ps2_data_in;
        repeat (10) @(negedge CLOCK_50);
        for (int k = 1; k <= 11 && !model_abort; k++) begin
          if (k == 11 && model_ack) begin
            dev_data_low = 1'b1;
            repeat (HALF / 2) @(negedge CLOCK_50);
          end
          dev_clk_low = 1'b1;
          dev_edge = k;
          repeat (HALF) @(negedge CLOCK_50);
          dev_clk_low = 1'b0;
          if (k <= 10) frame[k] = ps2_data_in;
          repeat (HALF) @(negedge CLOCK_50);
          dev_data_low = 1'b0;
        end
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        if (!model_abort) begin
          last_frame = frame;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL frame_unexpected observed=%0h expected=none", frame);
          end else begin
            check("frame_bits", frame, exp_q.pop_front());
          end
        end
        dev_edge = 0;
        model_busy = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 1000) begin @(negedge CLOCK_50); n++; end
    check("ready_wait", tx_ready, 1);
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!(tx_done || tx_err) && n < FRAME_MAX) begin @(negedge CLOCK_50); n++; end
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input bit ack);
    int n, d0, e0;
    model_ack = ack;
    d0 = done_cnt;
    e0 = err_cnt;
    wait_ready();
    tx_data = d;
    tx_valid = 1'b1;
    exp_q.push_back(frame_of(d));
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    wait_end(n);
    check({tag, "_end_in_time"}, n < FRAME_MAX, 1);
    repeat (3) @(negedge CLOCK_50);
    check({tag, "_done_pulses"}, done_cnt - d0, ack);
    check({tag, "_err_pulses"}, err_cnt - e0, !ack);
    check({tag, "_clk_released"}, ps2_clk_oe, 0);
    check({tag, "_data_released"}, ps2_data_oe, 0);
    check({tag, "_ready_back"}, tx_ready, 1);
  endtask

  initial begin
    int n, a0, d0, e0;

    resetn = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check("rst_ready", tx_ready, 1);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    resetn = 1'b1;
    repeat (4) @(negedge CLOCK_50);

    do_frame("t1_ed", CMD_SET_LED, 1'b1);
    check("t1_inhibit_len", last_run >= 6000, 1);
    check("t1_frame", last_frame, 11'b11111011010);

    do_frame("t2_00", 8'h00, 1'b1);
    check("t2_par_00", last_frame[9], 1);
    do_frame("t2_07", 8'h07, 1'b1);
    check("t2_par_07", last_frame[9], 0);
    do_frame("t2_ff", CMD_RESET, 1'b1);
    check("t2_par_ff", last_frame[9], 1);

    do_frame("t3_nack", CMD_ECHO, 1'b0);

    model_silent = 1'b1;
    e0 = err_cnt;
    wait_ready();
    tx_data = CMD_ECHO;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!tx_err && n < TB_TIMEOUT + 100) begin @(negedge CLOCK_50); n++; end
    check("t4_wd_timing", (n >= TB_TIMEOUT - 2) && (n <= TB_TIMEOUT + 8), 1);
    repeat (3) @(negedge CLOCK_50);
    check("t4_wd_err", err_cnt - e0, 1);
    check("t4_wd_clk_rel", ps2_clk_oe, 0);
    check("t4_wd_data_rel", ps2_data_oe, 0);
    check("t4_wd_ready", tx_ready, 1);
`else
    repeat (9000) @(negedge CLOCK_50);
    check("t4_stuck_ready", tx_ready, 0);
    check("t4_no_err", err_cnt - e0, 0);
    check("t4_start_held", ps2_data_oe, 1);
    resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);
`endif
    model_silent = 1'b0;

    model_ack = 1'b1;
    a0 = acc_cnt;
    d0 = done_cnt;
    wait_ready();
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    exp_q.push_back(frame_of(8'h5A));
    wait_end(n);
    check("t5_first_done", tx_done, 1);
    tx_data = CMD_ECHO;
    exp_q.push_back(frame_of(CMD_ECHO));
    @(negedge CLOCK_50);
    check("t5_ready_back", tx_ready, 1);
    check("t5_single_accept", acc_cnt - a0, 1);
    @(negedge CLOCK_50);
    check("t5_second_taken", tx_ready, 0);
    tx_valid = 1'b0;
    wait_end(n);
    repeat (3) @(negedge CLOCK_50);
    check("t5_two_accepts", acc_cnt - a0, 2);
    check("t5_two_done", done_cnt - d0, 2);

    wait_ready();
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    n = 0;
    while (dev_edge != 4 && n < FRAME_MAX) begin @(negedge CLOCK_50); n++; end
    check("t6_edge4", dev_edge, 4);
    repeat (10) @(negedge CLOCK_50);
    check("t6_data_driven", ps2_data_oe, 1);
    model_abort = 1'b1;
    resetn = 1'b0;
    #1;
    check("t6_rst_clk_oe", ps2_clk_oe, 0);
    check("t6_rst_data_oe", ps2_data_oe, 0);
    check("t6_rst_ready", tx_ready, 1);
    n = 0;
    while (model_busy && n < 500) begin @(negedge CLOCK_50); n++; end
    check("t6_model_idle", model_busy, 0);
    model_abort = 1'b0;
    resetn = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    do_frame("t6_clean", CMD_SET_LED, 1'b1);
    check("t6_frame", last_frame, 11'b11111011010);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
